// File: rtl/skid_register.sv
// Two-entry skid buffer: a fully registered valid/ready stage. Every output
// comes from a flop, so no input reaches an output combinationally.
module skid_register #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    input  logic                  FLUSH,
    output logic [1:0]            COUNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   main_q, main_d;
    logic [DATA_WIDTH-1:0]   skid_q, skid_d;
    logic                    s_ready_q, s_ready_d;
    logic                    m_valid_q, m_valid_d;
    logic [1:0]              count_q, count_d;
    logic                    up_s;
    logic                    dn_s;

    // Transfers are qualified by the registered handshake outputs only.
    assign up_s = S_VALID & s_ready_q;
    assign dn_s = m_valid_q & M_READY;

    // Next-state and storage update; FLUSH overrides any transfer on this edge.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_s) begin
                        main_d  = S_DATA;
                        state_d = ST_BUSY;
                    end else begin
                        main_d  = RESET_VALUE;
                    end
                end
                ST_BUSY: begin
                    if (up_s && dn_s) begin
                        main_d  = S_DATA;
                    end else if (up_s) begin
                        skid_d  = S_DATA;
                        state_d = ST_FULL;
                    end else if (dn_s) begin
                        main_d  = RESET_VALUE;
                        state_d = ST_EMPTY;
                    end else begin
                        main_d  = main_q;
                    end
                end
                ST_FULL: begin
                    if (dn_s) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end else begin
                        main_d  = main_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_VALUE;
                    skid_d  = RESET_VALUE;
                end
            endcase
        end
    end

    // Handshake and occupancy outputs are precomputed from the next state.
    always_comb begin
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
        count_d   = 2'd0;
        case (state_d)
            ST_EMPTY: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                count_d   = 2'd0;
            end
            ST_BUSY: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b1;
                count_d   = 2'd1;
            end
            ST_FULL: begin
                s_ready_d = 1'b0;
                m_valid_d = 1'b1;
                count_d   = 2'd2;
            end
            default: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                count_d   = 2'd0;
            end
        endcase
    end

    // State, storage and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= ST_EMPTY;
            main_q    <= RESET_VALUE;
            skid_q    <= RESET_VALUE;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
        end
    end

    assign S_READY = s_ready_q;
    assign M_VALID = m_valid_q;
    assign M_DATA  = main_q;
    assign COUNT   = count_q;

endmodule
